// File: rtl/bat_uop_sequencer_if.sv
// Control bus between the BatAmateur micro-op sequencer and its datapath.
// master: the sequencer (takes INSTR, ALU_FLAGS, RAM_READY, RUN; drives every strobe).
// slave:  the datapath (drives the status inputs, consumes the strobes).
// Strobes: PC_INC/PC_RW/PC_EN, MAR_LOAD/MAR_EN, RAM_RW/RAM_EN, IR_LOAD/IR_EN,
//          per-register REGS_INC/REGS_RW/REGS_EN, ALU_EN/ALU_OP, HALTED, FAULT, RETIRE.
interface bat_uop_sequencer_if #(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned ALU_OP_W = 5,
  parameter int unsigned FLAG_W   = 8
);
  logic [15:0]         INSTR;
  logic [FLAG_W-1:0]   ALU_FLAGS;
  logic                RAM_READY;
  logic                RUN;

  logic                PC_INC;
  logic                PC_RW;
  logic                PC_EN;
  logic                MAR_LOAD;
  logic                MAR_EN;
  logic                RAM_RW;
  logic                RAM_EN;
  logic                IR_LOAD;
  logic                IR_EN;
  logic [NUM_REGS-1:0] REGS_INC;
  logic [NUM_REGS-1:0] REGS_RW;
  logic [NUM_REGS-1:0] REGS_EN;
  logic                ALU_EN;
  logic [ALU_OP_W-1:0] ALU_OP;
  logic                HALTED;
  logic                FAULT;
  logic                RETIRE;

  modport master (
    input  INSTR, ALU_FLAGS, RAM_READY, RUN,
    output PC_INC, PC_RW, PC_EN, MAR_LOAD, MAR_EN, RAM_RW, RAM_EN, IR_LOAD, IR_EN,
           REGS_INC, REGS_RW, REGS_EN, ALU_EN, ALU_OP, HALTED, FAULT, RETIRE
  );

  modport slave (
    output INSTR, ALU_FLAGS, RAM_READY, RUN,
    input  PC_INC, PC_RW, PC_EN, MAR_LOAD, MAR_EN, RAM_RW, RAM_EN, IR_LOAD, IR_EN,
           REGS_INC, REGS_RW, REGS_EN, ALU_EN, ALU_OP, HALTED, FAULT, RETIRE
  );
endinterface

// File: rtl/bat_uop_sequencer.sv
// Micro-op sequencer for the BatAmateur datapath: fetch, decode and execute FSM that drives
// the bus enables and read/write strobes of PC, MAR, RAM, IR, register file and ALU.
// Ports:
//   CLK  - clock
//   RST  - synchronous, active-low reset (forces RST_S)
//   bus  - bat_uop_sequencer_if.master: instruction/flags/RAM_READY/RUN in, strobes out
// Strobes are combinational in state, INSTR, ALU_FLAGS and RAM_READY; only the state is stored.
module bat_uop_sequencer #(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned ALU_OP_W = 5,
  parameter int unsigned FLAG_W   = 8,
  parameter int unsigned FLAG_BIT = 0
) (
  input logic                 CLK,
  input logic                 RST,
  bat_uop_sequencer_if.master bus
);

  typedef enum logic [2:0] {RST_S, F_ADDR, F_IR, EX1, EX2, EX3, HALT, FAULT} state_e;

  localparam logic [NUM_REGS-1:0] RegA = NUM_REGS'(1);
  localparam logic [NUM_REGS-1:0] RegB = NUM_REGS'(2);

  state_e state_q, state_d;

  function automatic logic [NUM_REGS-1:0] reg_oh(input logic [2:0] idx);
    logic [NUM_REGS-1:0] v;
    v = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (int'(idx) == i) v[i] = 1'b1;
    end
    return v;
  endfunction

  logic [2:0]          rd, rs;
  logic [4:0]          op;
  logic                is_reg, is_mov, is_inc, is_halt, is_alu;
  logic                rd_bad, rs_bad, reg_fault;
  logic                flag, taken;
  logic [NUM_REGS-1:0] rd_oh, rs_oh, tgt_oh, alu_dst;
  logic                is_store;

  assign rd       = bus.INSTR[5:3];
  assign rs       = bus.INSTR[2:0];
  assign op       = bus.INSTR[11:7];
  // Register class shares INSTR[15:14] = 01 with direct jumps, so it is decoded first.
  assign is_reg   = (bus.INSTR[15:12] == 4'b0111);
  assign is_mov   = is_reg && (op == 5'b11111);
  assign is_inc   = is_reg && (op == 5'b11110);
  assign is_halt  = is_reg && (op == 5'b11101);
  assign is_alu   = is_reg && !is_mov && !is_inc && !is_halt;
  assign rd_bad   = (32'(rd) >= NUM_REGS);
  assign rs_bad   = (32'(rs) >= NUM_REGS);
  assign reg_fault = ((is_mov || is_alu) && (rd_bad || rs_bad)) || (is_inc && rd_bad);
  assign rd_oh    = reg_oh(rd);
  assign rs_oh    = reg_oh(rs);
  assign tgt_oh   = bus.INSTR[12] ? RegB : RegA;
  assign is_store = bus.INSTR[13];
  assign alu_dst  = bus.INSTR[6] ? RegA : RegB;
  assign flag     = bus.ALU_FLAGS[FLAG_BIT];

  always_comb begin
    unique case (bus.INSTR[13:12])
      2'b00:   taken = 1'b1;
      2'b01:   taken = !flag;
      2'b10:   taken = flag;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    // Idle control word is the base for every state.
    bus.PC_INC   = 1'b0;
    bus.PC_RW    = 1'b1;
    bus.PC_EN    = 1'b0;
    bus.MAR_LOAD = 1'b0;
    bus.MAR_EN   = 1'b1;
    bus.RAM_RW   = 1'b1;
    bus.RAM_EN   = 1'b0;
    bus.IR_LOAD  = 1'b0;
    bus.IR_EN    = 1'b0;
    bus.REGS_INC = '0;
    bus.REGS_RW  = '1;
    bus.REGS_EN  = '0;
    bus.ALU_EN   = 1'b0;
    bus.ALU_OP   = '0;
    bus.HALTED   = 1'b0;
    bus.FAULT    = 1'b0;
    bus.RETIRE   = 1'b0;
    state_d      = state_q;

    case (state_q)
      RST_S: state_d = F_ADDR;

      F_ADDR: begin
        bus.PC_EN    = 1'b1;
        bus.MAR_LOAD = 1'b1;
        state_d      = F_IR;
      end

      F_IR: begin
        bus.RAM_EN  = 1'b1;
        bus.IR_LOAD = 1'b1;
        bus.IR_EN   = 1'b1;
        if (bus.RAM_READY) begin
          bus.PC_INC = 1'b1;
          state_d    = EX1;
        end
      end

      EX1: begin
        if (is_reg) begin
          if (reg_fault) begin
            state_d = FAULT;
          end else if (is_mov) begin
            bus.REGS_EN = rd_oh | rs_oh;
            bus.REGS_RW = ~rd_oh | rs_oh;
            bus.RETIRE  = 1'b1;
            state_d     = F_ADDR;
          end else if (is_inc) begin
            bus.REGS_INC = rd_oh;
            bus.RETIRE   = 1'b1;
            state_d      = F_ADDR;
          end else if (is_halt) begin
            bus.RETIRE = 1'b1;
            state_d    = HALT;
          end else begin
            // Stage rd into A unless it already is A.
            if (rd != 3'd0) begin
              bus.REGS_EN = RegA | rd_oh;
              bus.REGS_RW = ~RegA;
            end
            state_d = EX2;
          end
        end else if (bus.INSTR[15:14] == 2'b01) begin
          // PC already advanced in F_IR, so a non-taken jump needs no PC strobes.
          if (taken) begin
            bus.IR_EN = 1'b1;
            bus.PC_EN = 1'b1;
            bus.PC_RW = 1'b0;
          end
          bus.RETIRE = 1'b1;
          state_d    = F_ADDR;
        end else begin
          bus.IR_EN    = 1'b1;
          bus.MAR_LOAD = 1'b1;
          state_d      = EX2;
        end
      end

      EX2: begin
        if (is_reg) begin
          // Stage rs into B unless it already is B.
          if (rs != 3'd1) begin
            bus.REGS_EN = RegB | rs_oh;
            bus.REGS_RW = ~RegB;
          end
          state_d = EX3;
        end else begin
          unique case (bus.INSTR[15:14])
            2'b11: begin
              if (taken) begin
                bus.RAM_EN = 1'b1;
                bus.PC_EN  = 1'b1;
                bus.PC_RW  = 1'b0;
              end
              if (!taken || bus.RAM_READY) begin
                bus.RETIRE = 1'b1;
                state_d    = F_ADDR;
              end
            end
            2'b00: begin
              bus.RAM_EN  = 1'b1;
              bus.REGS_EN = tgt_oh;
              if (is_store) bus.RAM_RW  = 1'b0;
              else          bus.REGS_RW = ~tgt_oh;
              if (bus.RAM_READY) begin
                bus.RETIRE = 1'b1;
                state_d    = F_ADDR;
              end
            end
            2'b10: begin
              // Fetch the pointer word back into MAR.
              bus.RAM_EN   = 1'b1;
              bus.MAR_LOAD = 1'b1;
              if (bus.RAM_READY) state_d = EX3;
            end
            default: state_d = FAULT;
          endcase
        end
      end

      EX3: begin
        if (is_reg) begin
          bus.ALU_EN  = 1'b1;
          bus.ALU_OP  = bus.INSTR[6+ALU_OP_W:7];
          bus.REGS_EN = alu_dst;
          bus.REGS_RW = ~alu_dst;
          bus.RETIRE  = 1'b1;
          state_d     = F_ADDR;
        end else begin
          bus.RAM_EN  = 1'b1;
          bus.REGS_EN = tgt_oh;
          if (is_store) bus.RAM_RW  = 1'b0;
          else          bus.REGS_RW = ~tgt_oh;
          if (bus.RAM_READY) begin
            bus.RETIRE = 1'b1;
            state_d    = F_ADDR;
          end
        end
      end

      HALT: begin
        bus.HALTED = 1'b1;
        if (bus.RUN) state_d = F_ADDR;
      end

      FAULT: bus.FAULT = 1'b1;

      default: state_d = FAULT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) state_q <= RST_S;
    else      state_q <= state_d;
  end

endmodule

// File: tb/tb_bat_uop_sequencer.sv
// Directed bench for bat_uop_sequencer (NUM_REGS = 4): reset, fetch, ALU op, jumps,
// indirect load with RAM wait, direct store, MOV, HALT/RUN, mid-instruction reset, fault.
module tb_bat_uop_sequencer;
  localparam int unsigned NR  = 4;
  localparam int unsigned OPW = 5;
  localparam int unsigned FW  = 8;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  bat_uop_sequencer_if #(.NUM_REGS(NR), .ALU_OP_W(OPW), .FLAG_W(FW)) bus ();

  bat_uop_sequencer #(
    .NUM_REGS(NR), .ALU_OP_W(OPW), .FLAG_W(FW), .FLAG_BIT(0)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  typedef struct packed {
    logic       pc_inc, pc_rw, pc_en, mar_load, mar_en, ram_rw, ram_en, ir_load, ir_en;
    logic [3:0] regs_inc, regs_rw, regs_en;
    logic       alu_en;
    logic [4:0] alu_op;
    logic       halted, fault, retire;
  } ctl_t;

  int n_cmp = 0;
  int n_err = 0;
  ctl_t e;

  function automatic ctl_t idle();
    ctl_t c;
    c = '0;
    c.pc_rw = 1'b1; c.mar_en = 1'b1; c.ram_rw = 1'b1; c.regs_rw = 4'hF;
    return c;
  endfunction

  function automatic ctl_t sample();
    ctl_t c;
    c.pc_inc = bus.PC_INC;   c.pc_rw = bus.PC_RW;   c.pc_en = bus.PC_EN;
    c.mar_load = bus.MAR_LOAD; c.mar_en = bus.MAR_EN;
    c.ram_rw = bus.RAM_RW;   c.ram_en = bus.RAM_EN;
    c.ir_load = bus.IR_LOAD; c.ir_en = bus.IR_EN;
    c.regs_inc = bus.REGS_INC; c.regs_rw = bus.REGS_RW; c.regs_en = bus.REGS_EN;
    c.alu_en = bus.ALU_EN;   c.alu_op = bus.ALU_OP;
    c.halted = bus.HALTED;   c.fault = bus.FAULT;   c.retire = bus.RETIRE;
    return c;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input ctl_t exp);
    ctl_t o;
    #1;
    o = sample();
    n_cmp++;
    assert (o === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, o, exp);
    end
  endtask

  // Called in F_ADDR; leaves the FSM in EX1 with RAM_READY = 1.
  task automatic fetch(input logic [15:0] instr);
    ctl_t f;
    bus.INSTR = instr;
    tick();
    f = idle(); f.ram_en = 1'b1; f.ir_load = 1'b1; f.ir_en = 1'b1; f.pc_inc = 1'b1;
    chk("fetch_f_ir", f);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b0; bus.INSTR = '0; bus.ALU_FLAGS = '0; bus.RAM_READY = 1'b1; bus.RUN = 1'b0;
    tick(); tick();
    chk("reset_idle", idle());

    RST = 1'b1;
    tick();
    e = idle(); e.pc_en = 1'b1; e.mar_load = 1'b1;
    chk("f_addr", e);

    // Fetch with a RAM wait, then the ALU op: 0111_00001_1_010_011.
    bus.RAM_READY = 1'b0; bus.INSTR = 16'h70D3;
    tick();
    e = idle(); e.ram_en = 1'b1; e.ir_load = 1'b1; e.ir_en = 1'b1;
    chk("f_ir_wait", e);
    tick();
    chk("f_ir_hold", e);
    bus.RAM_READY = 1'b1; e.pc_inc = 1'b1;
    chk("f_ir_ready", e);
    tick();
    e = idle(); e.regs_en = 4'h5; e.regs_rw = 4'hE;
    chk("alu_ex1", e);
    tick();
    e = idle(); e.regs_en = 4'hA; e.regs_rw = 4'hD;
    chk("alu_ex2", e);
    tick();
    e = idle(); e.alu_en = 1'b1; e.alu_op = 5'd1; e.regs_en = 4'h1; e.regs_rw = 4'hE;
    e.retire = 1'b1;
    chk("alu_ex3", e);
    tick();
    e = idle(); e.pc_en = 1'b1; e.mar_load = 1'b1;
    chk("alu_next_f_addr", e);

    // Direct jump if flag = 0.
    fetch(16'h5000);
    e = idle(); e.ir_en = 1'b1; e.pc_en = 1'b1; e.pc_rw = 1'b0; e.retire = 1'b1;
    chk("jmp_taken", e);
    bus.ALU_FLAGS = 8'h01;
    e = idle(); e.retire = 1'b1;
    chk("jmp_not_taken", e);
    bus.ALU_FLAGS = 8'h00;
    tick();

    // Indirect load into B with three wait cycles in EX3.
    fetch(16'h9000);
    e = idle(); e.ir_en = 1'b1; e.mar_load = 1'b1;
    chk("ild_ex1", e);
    tick();
    e = idle(); e.ram_en = 1'b1; e.mar_load = 1'b1;
    chk("ild_ex2", e);
    tick();
    bus.RAM_READY = 1'b0;
    e = idle(); e.ram_en = 1'b1; e.regs_en = 4'h2; e.regs_rw = 4'hD;
    for (int i = 0; i < 3; i++) begin
      chk("ild_ex3_wait", e);
      tick();
    end
    bus.RAM_READY = 1'b1; e.retire = 1'b1;
    chk("ild_ex3_done", e);
    tick();
    e = idle(); e.pc_en = 1'b1; e.mar_load = 1'b1;
    chk("ild_next_f_addr", e);

    // Direct store from A.
    fetch(16'h2000);
    e = idle(); e.ir_en = 1'b1; e.mar_load = 1'b1;
    chk("dst_ex1", e);
    tick();
    e = idle(); e.ram_en = 1'b1; e.ram_rw = 1'b0; e.regs_en = 4'h1; e.retire = 1'b1;
    chk("dst_ex2", e);
    tick();

    // MOV rd = 1, rs = 2.
    fetch(16'h7F8A);
    e = idle(); e.regs_en = 4'h6; e.regs_rw = 4'hD; e.retire = 1'b1;
    chk("mov_ex1", e);
    tick();

    // HALT, then RUN.
    fetch(16'h7E80);
    e = idle(); e.retire = 1'b1;
    chk("halt_ex1", e);
    tick();
    e = idle(); e.halted = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("halt_hold", e);
      tick();
    end
    bus.RUN = 1'b1;
    tick();
    bus.RUN = 1'b0;
    e = idle(); e.pc_en = 1'b1; e.mar_load = 1'b1;
    chk("run_f_addr", e);

    // Reset during EX2 of an ALU op.
    fetch(16'h70D3);
    tick();
    e = idle(); e.regs_en = 4'hA; e.regs_rw = 4'hD;
    chk("mid_alu_ex2", e);
    RST = 1'b0;
    tick();
    chk("mid_reset_idle", idle());
    RST = 1'b1;
    tick();
    e = idle(); e.pc_en = 1'b1; e.mar_load = 1'b1;
    chk("mid_reset_f_addr", e);

    // MOV rd = 5 is out of range for four registers.
    fetch(16'h7FA8);
    chk("fault_ex1_quiet", idle());
    tick();
    bus.RUN = 1'b1;
    e = idle(); e.fault = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("fault_sticky", e);
      tick();
    end
    bus.RUN = 1'b0;
    RST = 1'b0;
    tick();
    chk("fault_cleared", idle());
    RST = 1'b1;
    tick();
    e = idle(); e.pc_en = 1'b1; e.mar_load = 1'b1;
    chk("fault_reset_f_addr", e);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/bat_uop_sequencer.md
Name: bat_uop_sequencer

Overview:
Parametrised micro-op sequencer for the BatAmateur datapath. It drives the bus-enable and read/write strobes for PC, MAR, RAM, IR, the register file and the ALU. It is built as an explicit FSM. Relative to the first-generation controller it adds a configurable register count, RAM wait states, HALT/RUN, an illegal-register fault, and an instruction-retire strobe.

Parameters:
NUM_REGS, 8, register-file size (2..8); index 0 = A, index 1 = B.
ALU_OP_W, 5, ALU opcode width; driven from INSTR[6+ALU_OP_W:7].
FLAG_W, 8, width of ALU_FLAGS.
FLAG_BIT, 0, ALU_FLAGS bit used as the branch condition.

Ports:
CLK  in  1  clock.
RST  in  1  reset, synchronous, active-low.
INSTR  in  16  current IR contents.
ALU_FLAGS  in  FLAG_W  ALU status register.
RAM_READY  in  1  RAM access completes this cycle.
RUN  in  1  leave HALT.
PC_INC, PC_RW, PC_EN  out  1  PC controls (RW: 1 = read to bus, 0 = load).
MAR_LOAD, MAR_EN  out  1  MAR controls.
RAM_RW, RAM_EN  out  1  RAM controls (RW: 1 = read).
IR_LOAD, IR_EN  out  1  IR controls.
REGS_INC, REGS_RW, REGS_EN  out  NUM_REGS  per-register controls (RW: 1 = read to bus).
ALU_EN  out  1  ALU drives the bus.
ALU_OP  out  ALU_OP_W  ALU operation.
HALTED  out  1  in the HALT state.
FAULT  out  1  in the FAULT state (sticky).
RETIRE  out  1  one-cycle pulse on the last cycle of each instruction.

Behaviour:
- States: RST_S, F_ADDR, F_IR, EX1, EX2, EX3, HALT, FAULT. The state register updates on posedge CLK.
- Outputs are a combinational function of state, INSTR, ALU_FLAGS and RAM_READY.
- Idle control word: PC_RW = 1, MAR_EN = 1, RAM_RW = 1, REGS_RW = all ones; every other output 0. The idle word is driven in RST_S, HALT and FAULT, and as the base in every state.
- Reset: if RST = 0 at a clock edge, next state = RST_S from any state, including mid-instruction and mid-wait. RST_S goes to F_ADDR on the first edge with RST = 1.
- F_ADDR: PC_EN = 1 and MAR_LOAD = 1. Next state F_IR.
- F_IR: RAM_EN = 1, IR_LOAD = 1, IR_EN = 1. PC_INC = 1 only when RAM_READY = 1. The FSM stays in F_IR while RAM_READY = 0, then goes to EX1.
- General RAM wait rule: every state with RAM_EN = 1 holds until RAM_READY = 1. While held, all level controls stay asserted, and RETIRE and PC_INC are suppressed.
- Decode: rd = INSTR[5:3], rs = INSTR[2:0], op = INSTR[11:7].
- Fault check in EX1: if a decoded register index is >= NUM_REGS, next state = FAULT with no datapath strobes. FAULT is left only by reset.
- Register class (INSTR[15:12] = 0111):
  - MOV (op 11111), EX1: REGS_EN[rd] = 1; REGS_EN[rs] = 1 with REGS_RW[rs] = 1. Then retire.
  - INC (op 11110), EX1: REGS_INC[rd] = 1. Then retire.
  - HALT (op 11101), EX1: retire, next state HALT. HALT goes to F_ADDR on the edge where RUN = 1.
  - ALU op, EX1: if rd != 0, write A from rd. Next state EX2.
  - ALU op, EX2: if rs != 1, write B from rs. Next state EX3.
  - ALU op, EX3: ALU_EN = 1 and ALU_OP = op. Write A if INSTR[6] = 1, else write B. Then retire.
  - ALU op latency: 5 cycles with no waits.
- Branch condition: cond = INSTR[13:12]. 00 = always taken; 01 = taken if flag = 0; 10 = taken if flag = 1; 11 = never taken. Not taken means no PC strobes, since PC already advanced in F_IR.
- Direct jump (INSTR[15:14] = 01), EX1: if taken, IR_EN = 1, PC_EN = 1, PC_RW = 0. Then retire.
- Indirect jump (INSTR[15:14] = 11):
  - EX1: IR_EN = 1, MAR_LOAD = 1.
  - EX2: if taken, RAM_EN = 1, PC_EN = 1, PC_RW = 0, with wait. Retire.
- Direct load/store (INSTR[15:14] = 00):
  - EX1: IR_EN = 1, MAR_LOAD = 1.
  - EX2: transfer, with wait. Retire.
- Indirect load/store (INSTR[15:14] = 10):
  - EX1: IR_EN = 1, MAR_LOAD = 1.
  - EX2: RAM_EN = 1, MAR_LOAD = 1, with wait.
  - EX3: transfer, with wait. Retire.
- Transfer: the target register is A if INSTR[12] = 0, else B.
  - Store (INSTR[13] = 1): REGS_EN/REGS_RW = 1 on the target, RAM_EN = 1, RAM_RW = 0.
  - Load: REGS_EN = 1 and REGS_RW = 0 on the target, RAM_EN = 1, RAM_RW = 1.
- Retire: RETIRE = 1 in the final state, gated by RAM_READY if that state accesses RAM. Next state F_ADDR (or HALT for HALT).
- No output is X after reset; the default case drives the idle word and goes to FAULT.

Test Plan:
- RST = 0 for 2 cycles, then 1 → idle word in RST_S; F_ADDR next (PC_EN = 1, MAR_LOAD = 1); F_IR after that with PC_INC = 1 when RAM_READY = 1.
- INSTR = 0111_00001_1_010_011 (ALU op 1, rd = 2, rs = 3, dest A) → EX1 REGS_EN = 0x05 with REGS_RW[0] = 0; EX2 REGS_EN = 0x0A; EX3 ALU_OP = 1, ALU_EN = 1, REGS_EN = 0x01; RETIRE; 5 cycles total.
- INSTR = 0x5000 (jump if flag = 0): with flag = 0 → EX1 PC_EN = 1, PC_RW = 0, IR_EN = 1; with flag = 1 → PC_EN = 0 and PC_INC = 0, RETIRE only.
- Indirect load B (INSTR = 0x9xxx) with RAM_READY low for 3 cycles in EX3 → RAM_EN, REGS_EN[1] held 4 cycles; RETIRE exactly once.
- NUM_REGS = 4, MOV rd = 5 → FAULT = 1 persists for 10 cycles; cleared only by RST = 0.
- HALT (op 11101) → HALTED = 1; RUN = 0 for 5 cycles keeps HALTED = 1; RUN = 1 → F_ADDR next cycle. RST = 0 asserted mid-EX2 → RST_S on the next edge.
